// File: rtl/mem_link_pkg.sv
// Shared constants, FSM state type and message builders for the memory link.
// Message lengths are in link units; payloads are 256 bits, zero-padded.
package mem_link_pkg;

  localparam logic [4:0] LEN_READ  = 5'd5;
  localparam logic [4:0] LEN_WRITE = 5'd9;
  localparam logic [4:0] LEN_RESP  = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } state_t;

  // Read request: [31:0]=addr, [32]=0 marks a read.
  function automatic logic [255:0] read_msg(
    input logic [31:0] addr
  );
    read_msg = {223'd0, 1'b0, addr};
  endfunction

  // Write request: [31:0]=wdata, [63:32]=addr, [67:64]=byte mask.
  function automatic logic [255:0] write_msg(
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [3:0]  mask
  );
    write_msg = {188'd0, mask, addr, wdata};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester ports (IF, DM), memory link ports and error pulse.
// slave: arbiter side; master: requesters plus link side.
interface mem_port_arbiter_if;

  logic         if_req;
  logic [31:0]  if_addr;
  logic [127:0] if_rdata;
  logic         if_done;

  logic         dm_req;
  logic         dm_we;
  logic [31:0]  dm_addr;
  logic [31:0]  dm_wdata;
  logic [3:0]   dm_mask;
  logic [127:0] dm_rdata;
  logic         dm_done;

  logic         send_flag;
  logic [4:0]   send_length;
  logic [255:0] send_data;
  logic         sendable;

  logic         recv_flag;
  logic [4:0]   recv_length;
  logic [255:0] recv_data;
  logic         recvable;

  logic         err;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_done,
    input  dm_req, dm_we, dm_addr,
    input  dm_wdata, dm_mask,
    output dm_rdata, dm_done,
    output send_flag, send_length,
    output send_data,
    input  sendable,
    output recv_flag,
    input  recv_length, recv_data,
    input  recvable,
    output err
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_done,
    output dm_req, dm_we, dm_addr,
    output dm_wdata, dm_mask,
    input  dm_rdata, dm_done,
    input  send_flag, send_length,
    input  send_data,
    output sendable,
    input  recv_flag,
    output recv_length, recv_data,
    output recvable,
    input  err
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Two-way round-robin pick between IF (a) and DM (b) requesters.
// Ports: clk, rst, req_if, req_dm, upd/upd_dm (record winner), pick_dm.
module mem_arb_grant (
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_dm,
  input  logic upd,
  input  logic upd_dm,
  output logic pick_dm
);

  // last_dm=1 means DM was served last, so IF is preferred.
  logic last_dm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dm <= 1'b1;
    end else if (upd) begin
      last_dm <= upd_dm;
    end
  end

  assign pick_dm = req_dm & (~req_if | ~last_dm);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF line reads and DM reads/masked writes onto one memory link.
// Ports: clk, rst, bus (slave). MEM_ARB_TIMEOUT_EN bounds the response wait.
module mem_port_arbiter
  import mem_link_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  state_t state;
  state_t state_nx;

  logic         gnt_dm;
  logic         is_wr;
  logic         pick_dm;
  logic         any_req;
  logic         rsp_ok;
  logic         start;
  logic         got;
  logic         fin;
  logic         tmo;
  logic [4:0]   len_q;
  logic [255:0] msg_q;
  logic [127:0] if_line;
  logic [127:0] dm_line;

  logic         send_flag_c;
  logic         recv_flag_c;
  logic         err_c;
  logic         if_done_c;
  logic         dm_done_c;

  assign any_req = bus.if_req | bus.dm_req;
  assign rsp_ok  = bus.recvable &&
                   (bus.recv_length == LEN_RESP);
  assign start   = (state == IDLE) && any_req;
  assign got     = (state == WAIT) && rsp_ok;
  assign fin     = (state == DONE);

  mem_arb_grant u_grant (
    .clk     (clk),
    .rst     (rst),
    .req_if  (bus.if_req),
    .req_dm  (bus.dm_req),
    .upd     (fin),
    .upd_dm  (gnt_dm),
    .pick_dm (pick_dm)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Counts WAIT cycles; held at zero outside WAIT so
  // each entry starts a fresh window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state != WAIT) begin
      cnt <= '0;
    end else if (!tmo) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tmo = (state == WAIT) && !rsp_ok &&
               (cnt == CW'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;

  assign tmo = 1'b0;
`endif

  logic unused_hi;
  assign unused_hi = ^bus.recv_data[255:128];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    send_flag_c = 1'b0;
    if_done_c   = 1'b0;
    dm_done_c   = 1'b0;
    // The link is popped in every state; anything
    // other than a good response in WAIT is an error.
    recv_flag_c = !rst && bus.recvable;
    err_c       = !rst &&
                  ((bus.recvable && !got) || tmo);
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = SEND;
        end
      end
      SEND: begin
        if (bus.sendable) begin
          send_flag_c = 1'b1;
          state_nx    = is_wr ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (rsp_ok || tmo) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if_done_c = !gnt_dm;
        dm_done_c = gnt_dm;
        state_nx  = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_dm  <= 1'b0;
      is_wr   <= 1'b0;
      len_q   <= '0;
      msg_q   <= '0;
      if_line <= '0;
      dm_line <= '0;
    end else begin
      if (start) begin
        gnt_dm <= pick_dm;
        is_wr  <= pick_dm && bus.dm_we;
        if (pick_dm && bus.dm_we) begin
          len_q <= LEN_WRITE;
          msg_q <= write_msg(bus.dm_addr,
                             bus.dm_wdata,
                             bus.dm_mask);
        end else begin
          len_q <= LEN_READ;
          msg_q <= read_msg(pick_dm ?
                            bus.dm_addr :
                            bus.if_addr);
        end
      end
      // A timed-out read completes with an empty line.
      if (got || tmo) begin
        if (gnt_dm) begin
          dm_line <= got ? bus.recv_data[127:0] : '0;
        end else begin
          if_line <= got ? bus.recv_data[127:0] : '0;
        end
      end
    end
  end

  assign bus.send_flag   = send_flag_c;
  assign bus.send_length = len_q;
  assign bus.send_data   = msg_q;
  assign bus.recv_flag   = recv_flag_c;
  assign bus.err         = err_c;
  assign bus.if_done     = if_done_c;
  assign bus.dm_done     = dm_done_c;
  assign bus.if_rdata    = if_line;
  assign bus.dm_rdata    = dm_line;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  function automatic logic [255:0] exp_msg(
    input bit we, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [3:0] mask);
    logic [255:0] m;
    m = '0;
    if (we) begin
      m[31:0]  = wdata;
      m[63:32] = addr;
      m[67:64] = mask;
    end else begin
      m[31:0] = addr;
    end
    return m;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0;
    bus.dm_wdata = 0; bus.dm_mask = 0;
    bus.sendable = 0; bus.recvable = 0;
    bus.recv_length = 0; bus.recv_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    bus.if_req = 1; bus.dm_req = 1; bus.sendable = 1;
    @(negedge clk);
    n_run++; if ({bus.send_flag, bus.recv_flag, bus.err, bus.if_done, bus.dm_done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b want=00000", {bus.send_flag, bus.recv_flag, bus.err, bus.if_done, bus.dm_done}); end
    n_run++; if (bus.send_length !== 5'd0 || bus.send_data !== '0) begin
      n_fail++; $display("FAIL reset_send got len=%0d data=%h want 0", bus.send_length, bus.send_data); end
    n_run++; if (bus.if_rdata !== '0 || bus.dm_rdata !== '0) begin
      n_fail++; $display("FAIL reset_rdata got if=%h dm=%h want 0", bus.if_rdata, bus.dm_rdata); end
    nxt();
    rst = 0;
    idle_inputs();
    nxt();
  endtask

  task automatic test_if_read();
    logic [255:0] d;
    d = rnd256();
    d[31:0] = 32'h0C0B0A09;
    apply_reset();
    bus.if_req = 1; bus.if_addr = 32'h10; bus.sendable = 1;
    @(negedge clk);
    n_run++; if (bus.send_flag !== 1'b0) begin
      n_fail++; $display("FAIL rd_idle_send got=%b want=0", bus.send_flag); end
    nxt(); @(negedge clk);
    n_run++; if (bus.send_flag !== 1'b1 || bus.send_length !== 5'd5) begin
      n_fail++; $display("FAIL rd_send got flag=%b len=%0d want 1/5", bus.send_flag, bus.send_length); end
    n_run++; if (bus.send_data !== exp_msg(0, 32'h10, 0, 0)) begin
      n_fail++; $display("FAIL rd_msg got=%h want=%h", bus.send_data, exp_msg(0, 32'h10, 0, 0)); end
    nxt();
    bus.recvable = 1; bus.recv_length = 16; bus.recv_data = d;
    @(negedge clk);
    n_run++; if ({bus.recv_flag, bus.err, bus.if_done, bus.send_flag} !== 4'b1000) begin
      n_fail++; $display("FAIL rd_resp got=%b want=1000", {bus.recv_flag, bus.err, bus.if_done, bus.send_flag}); end
    nxt();
    bus.recvable = 0;
    @(negedge clk);
    n_run++; if (bus.if_done !== 1'b1 || bus.dm_done !== 1'b0) begin
      n_fail++; $display("FAIL rd_done got if=%b dm=%b want 1/0", bus.if_done, bus.dm_done); end
    n_run++; if (bus.if_rdata !== d[127:0]) begin
      n_fail++; $display("FAIL rd_line got=%h want=%h", bus.if_rdata, d[127:0]); end
    nxt();
    bus.if_req = 0;
    @(negedge clk);
    n_run++; if (bus.if_done !== 1'b0 || bus.if_rdata !== d[127:0]) begin
      n_fail++; $display("FAIL rd_after got done=%b line=%h want 0/%h", bus.if_done, bus.if_rdata, d[127:0]); end
  endtask

  task automatic test_dm_write();
    apply_reset();
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h100;
    bus.dm_wdata = 32'hDEADBEEF; bus.dm_mask = 4'h3; bus.sendable = 1;
    @(negedge clk);
    n_run++; if (bus.dm_done !== 1'b0) begin
      n_fail++; $display("FAIL wr_early_done got=%b want=0", bus.dm_done); end
    nxt(); @(negedge clk);
    n_run++; if (bus.send_flag !== 1'b1 || bus.send_length !== 5'd9) begin
      n_fail++; $display("FAIL wr_send got flag=%b len=%0d want 1/9", bus.send_flag, bus.send_length); end
    n_run++; if (bus.send_data !== {188'd0, 68'h3_00000100_DEADBEEF}) begin
      n_fail++; $display("FAIL wr_msg got=%h want=%h", bus.send_data, {188'd0, 68'h3_00000100_DEADBEEF}); end
    nxt(); @(negedge clk);
    n_run++; if (bus.dm_done !== 1'b1 || bus.if_done !== 1'b0 || bus.dm_rdata !== '0) begin
      n_fail++; $display("FAIL wr_done got dm=%b if=%b line=%h want 1/0/0", bus.dm_done, bus.if_done, bus.dm_rdata); end
    nxt();
    bus.dm_req = 0;
    @(negedge clk);
    n_run++; if (bus.dm_done !== 1'b0 || bus.send_flag !== 1'b0) begin
      n_fail++; $display("FAIL wr_after got done=%b flag=%b want 0/0", bus.dm_done, bus.send_flag); end
  endtask

  task automatic test_sendable_stall();
    int pulses;
    pulses = 0;
    apply_reset();
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = $urandom;
    bus.dm_wdata = $urandom; bus.dm_mask = 4'hF; bus.sendable = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      nxt(); @(negedge clk);
      if (bus.send_flag) pulses++;
    end
    n_run++; if (pulses !== 0) begin
      n_fail++; $display("FAIL stall_low got pulses=%0d want=0", pulses); end
    nxt();
    bus.sendable = 1;
    @(negedge clk);
    n_run++; if (bus.send_flag !== 1'b1 || bus.send_data !== exp_msg(1, bus.dm_addr, bus.dm_wdata, 4'hF)) begin
      n_fail++; $display("FAIL stall_pulse got flag=%b data=%h", bus.send_flag, bus.send_data); end
    nxt(); @(negedge clk);
    n_run++; if (bus.send_flag !== 1'b0 || bus.dm_done !== 1'b1) begin
      n_fail++; $display("FAIL stall_done got flag=%b done=%b want 0/1", bus.send_flag, bus.dm_done); end
    nxt();
    bus.dm_req = 0;
    @(negedge clk);
    n_run++; if (bus.send_flag !== 1'b0 || bus.dm_done !== 1'b0) begin
      n_fail++; $display("FAIL stall_after got flag=%b done=%b want 0/0", bus.send_flag, bus.dm_done); end
  endtask

  task automatic test_bad_length();
    logic [255:0] d;
    d = rnd256();
    apply_reset();
    bus.if_req = 1; bus.if_addr = $urandom; bus.sendable = 1;
    nxt(); nxt();
    bus.recvable = 1; bus.recv_length = 5; bus.recv_data = rnd256();
    @(negedge clk);
    n_run++; if ({bus.recv_flag, bus.err, bus.if_done} !== 3'b110) begin
      n_fail++; $display("FAIL bad_len got=%b want=110", {bus.recv_flag, bus.err, bus.if_done}); end
    nxt();
    bus.recv_length = 16; bus.recv_data = d;
    @(negedge clk);
    n_run++; if ({bus.recv_flag, bus.err, bus.if_done} !== 3'b100) begin
      n_fail++; $display("FAIL good_len got=%b want=100", {bus.recv_flag, bus.err, bus.if_done}); end
    nxt();
    bus.recvable = 0;
    @(negedge clk);
    n_run++; if (bus.if_done !== 1'b1 || bus.if_rdata !== d[127:0]) begin
      n_fail++; $display("FAIL bad_then_good got done=%b line=%h want 1/%h", bus.if_done, bus.if_rdata, d[127:0]); end
    nxt();
    bus.if_req = 0;
  endtask

  task automatic test_stray_idle();
    apply_reset();
    bus.recvable = 1; bus.recv_length = 16; bus.recv_data = rnd256();
    @(negedge clk);
    n_run++; if ({bus.recv_flag, bus.err, bus.if_done, bus.dm_done} !== 4'b1100) begin
      n_fail++; $display("FAIL stray_pop got=%b want=1100", {bus.recv_flag, bus.err, bus.if_done, bus.dm_done}); end
    nxt();
    bus.recvable = 0;
    @(negedge clk);
    n_run++; if ({bus.recv_flag, bus.err} !== 2'b00 || bus.if_rdata !== '0) begin
      n_fail++; $display("FAIL stray_after got=%b line=%h want 00/0", {bus.recv_flag, bus.err}, bus.if_rdata); end
  endtask

  task automatic test_reset_in_wait();
    logic [255:0] d1;
    logic [255:0] d2;
    d1 = rnd256(); d2 = rnd256();
    apply_reset();
    bus.if_req = 1; bus.if_addr = $urandom; bus.sendable = 1;
    nxt(); nxt();
    bus.recvable = 1; bus.recv_length = 16; bus.recv_data = d1;
    nxt();
    bus.recvable = 0;
    nxt();
    bus.if_req = 0;
    @(negedge clk);
    n_run++; if (bus.if_rdata !== d1[127:0]) begin
      n_fail++; $display("FAIL rw_first got=%h want=%h", bus.if_rdata, d1[127:0]); end
    nxt();
    bus.if_req = 1; bus.if_addr = $urandom;
    nxt(); nxt();
    rst = 1; bus.if_req = 0; bus.sendable = 0;
    @(negedge clk);
    n_run++; if ({bus.send_flag, bus.send_length, bus.send_data, bus.if_rdata, bus.dm_rdata, bus.if_done, bus.dm_done, bus.err, bus.recv_flag} !== '0) begin
      n_fail++; $display("FAIL rw_outputs got len=%0d line=%h want all 0", bus.send_length, bus.if_rdata); end
    nxt();
    rst = 0;
    bus.recvable = 1; bus.recv_length = 16; bus.recv_data = d2;
    @(negedge clk);
    n_run++; if ({bus.recv_flag, bus.err, bus.if_done} !== 3'b110) begin
      n_fail++; $display("FAIL rw_late got=%b want=110", {bus.recv_flag, bus.err, bus.if_done}); end
    nxt();
    bus.recvable = 0;
    @(negedge clk);
    n_run++; if (bus.if_done !== 1'b0 || bus.if_rdata !== '0 || bus.send_flag !== 1'b0) begin
      n_fail++; $display("FAIL rw_after got done=%b line=%h want 0/0", bus.if_done, bus.if_rdata); end
  endtask

  // Requesters, link and a transaction-level model run in one
  // cycle loop. sat=1 keeps both requesters always pending.
  task automatic run_traffic(input int n_each, input bit sat);
    bit act[2];
    bit we[2];
    bit seen[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic [3:0] mask[2];
    int gap[2];
    int issued[2];
    int done_cnt[2];
    logic [127:0] mrd[2];
    logic [255:0] rsp;
    logic [4:0] bad;
    bit free, exp_send, grant_now, done_next, done_now;
    bit rsp_pend, good_now;
    int owner, last, rsp_dly, cyc, order_idx;
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; we[p] = 0; seen[p] = 0; addr[p] = 0;
      wdata[p] = 0; mask[p] = 0; gap[p] = 0;
      issued[p] = 0; done_cnt[p] = 0; mrd[p] = '0;
    end
    free = 1; exp_send = 0; grant_now = 0;
    done_next = 0; done_now = 0; rsp_pend = 0; good_now = 0;
    owner = 0; last = 1; rsp_dly = 0; cyc = 0; order_idx = 0;
    apply_reset();
    while ((done_cnt[0] < n_each || done_cnt[1] < n_each) && cyc < 5000) begin
      nxt();
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (seen[p]) begin
          act[p] = 0; seen[p] = 0;
          gap[p] = sat ? 0 : $urandom_range(0, 3);
        end
        if (!act[p] && issued[p] < n_each) begin
          if (gap[p] > 0) gap[p]--;
          else begin
            act[p] = 1; issued[p]++;
            we[p] = (p == 1) && ($urandom_range(0, 1) == 1);
            addr[p] = $urandom; wdata[p] = $urandom;
            mask[p] = 4'($urandom_range(0, 15));
          end
        end
      end
      bus.if_req = act[0]; bus.if_addr = addr[0];
      bus.dm_req = act[1]; bus.dm_we = we[1]; bus.dm_addr = addr[1];
      bus.dm_wdata = wdata[1]; bus.dm_mask = mask[1];
      if (free && (act[0] || act[1])) begin
        if (act[0] && act[1]) owner = 1 - last;
        else owner = act[1] ? 1 : 0;
        free = 0; grant_now = 1;
      end
      done_now = done_next; done_next = 0;
      bus.sendable = sat ? 1'b1 : ($urandom_range(0, 3) != 0);
      good_now = 0; bus.recvable = 0;
      if (rsp_pend) begin
        if (rsp_dly > 0) rsp_dly--;
        else begin
          rsp = rnd256();
          bus.recvable = 1; bus.recv_data = rsp;
          if (!sat && $urandom_range(0, 4) == 0) begin
            bad = 5'($urandom_range(0, 31));
            if (bad == 5'd16) bad = 5'd0;
            bus.recv_length = bad;
          end else begin
            bus.recv_length = 16; good_now = 1; rsp_pend = 0;
          end
        end
      end
      @(negedge clk);
      n_run++; if (bus.send_flag !== (exp_send && bus.sendable)) begin
        n_fail++; $display("FAIL tr_send_flag cyc=%0d got=%b want=%b", cyc, bus.send_flag, exp_send && bus.sendable); end
      if (bus.send_flag && exp_send) begin
        n_run++; if (bus.send_length !== (we[owner] ? 5'd9 : 5'd5)) begin
          n_fail++; $display("FAIL tr_len cyc=%0d got=%0d want=%0d", cyc, bus.send_length, we[owner] ? 9 : 5); end
        n_run++; if (bus.send_data !== exp_msg(we[owner], addr[owner], wdata[owner], mask[owner])) begin
          n_fail++; $display("FAIL tr_msg cyc=%0d owner=%0d got=%h want=%h", cyc, owner, bus.send_data, exp_msg(we[owner], addr[owner], wdata[owner], mask[owner])); end
        exp_send = 0;
        if (we[owner]) done_next = 1;
        else begin
          rsp_pend = 1;
          rsp_dly = sat ? 0 : $urandom_range(0, 3);
        end
      end
      n_run++; if (bus.recv_flag !== bus.recvable || bus.err !== (bus.recvable && !good_now)) begin
        n_fail++; $display("FAIL tr_link cyc=%0d got rf=%b err=%b want %b/%b", cyc, bus.recv_flag, bus.err, bus.recvable, bus.recvable && !good_now); end
      if (good_now) begin
        mrd[owner] = rsp[127:0]; done_next = 1;
      end
      n_run++; if ({bus.dm_done, bus.if_done} !== (done_now ? (owner == 1 ? 2'b10 : 2'b01) : 2'b00)) begin
        n_fail++; $display("FAIL tr_done cyc=%0d got dm/if=%b%b owner=%0d due=%b", cyc, bus.dm_done, bus.if_done, owner, done_now); end
      if (done_now) begin
        n_run++; if (bus.if_rdata !== mrd[0] || bus.dm_rdata !== mrd[1]) begin
          n_fail++; $display("FAIL tr_rdata cyc=%0d got if=%h dm=%h want if=%h dm=%h", cyc, bus.if_rdata, bus.dm_rdata, mrd[0], mrd[1]); end
        if (sat) begin
          n_run++; if (owner !== (order_idx % 2)) begin
            n_fail++; $display("FAIL tr_alternate idx=%0d got=%0d want=%0d", order_idx, owner, order_idx % 2); end
        end
        order_idx++;
        done_cnt[owner]++; seen[owner] = 1; last = owner; free = 1;
      end
      if (grant_now) begin
        exp_send = 1; grant_now = 0;
      end
    end
    n_run++; if (cyc >= 5000) begin
      n_fail++; $display("FAIL tr_budget got if=%0d dm=%0d dones want %0d each", done_cnt[0], done_cnt[1], n_each); end
    idle_inputs();
    nxt();
  endtask

  task automatic test_back_to_back();
    run_traffic(6, 1'b1);
  endtask

  task automatic test_random();
    run_traffic(40, 1'b0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_if_read();
    test_dm_write();
    test_sendable_stall();
    test_bad_length();
    test_stray_idle();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
